// File: rtl/mem_bank_xbar_rr.sv
// mem_bank_xbar_rr: NUM_PE x NUM_BANK memory crossbar with per-bank round-robin arbitration and a one-cycle registered response path
// Ports:
//   clk_i, rst_i                : clock, async active-high reset
//   req_i/we_i/be_i/addr_i/wdata_i : packed per-PE request channel
//   gnt_o, rvalid_o, rdata_o    : per-PE grant (same cycle) and response (next cycle)
//   bank_*_o, bank_rdata_i      : per-bank SRAM port, read data valid one cycle after bank_req_o
module mem_bank_xbar_rr #(
  parameter int NUM_PE   = 4,
  parameter int NUM_BANK = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int BANK_LSB = 14
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_PE-1:0]        req_i,
  input  logic [NUM_PE-1:0]        we_i,
  input  logic [NUM_PE*DW/8-1:0]   be_i,
  input  logic [NUM_PE*AW-1:0]     addr_i,
  input  logic [NUM_PE*DW-1:0]     wdata_i,
  output logic [NUM_PE-1:0]        gnt_o,
  output logic [NUM_PE-1:0]        rvalid_o,
  output logic [NUM_PE*DW-1:0]     rdata_o,
  output logic [NUM_BANK-1:0]      bank_req_o,
  output logic [NUM_BANK-1:0]      bank_we_o,
  output logic [NUM_BANK*DW/8-1:0] bank_be_o,
  output logic [NUM_BANK*AW-1:0]   bank_addr_o,
  output logic [NUM_BANK*DW-1:0]   bank_wdata_o,
  input  logic [NUM_BANK*DW-1:0]   bank_rdata_i
);
  localparam int BW  = $clog2(NUM_BANK);
  localparam int PW  = $clog2(NUM_PE);
  localparam int BEW = DW / 8;
  logic [PW-1:0]       ptr    [NUM_BANK];
  logic [PW-1:0]       win    [NUM_BANK];
  logic [PW-1:0]       rsp_pe [NUM_BANK];
  logic [NUM_BANK-1:0] hit, rsp_vld, rsp_we;
  logic                found;
  int                  k;
  always_comb begin
    gnt_o        = '0;
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_be_o    = '0;
    bank_addr_o  = '0;
    bank_wdata_o = '0;
    hit          = '0;
    found        = 1'b0;
    k            = 0;
    for (int b = 0; b < NUM_BANK; b++) begin
      win[b] = '0;
      found  = 1'b0;
      // scan starting at the pointer so the first hit is the round-robin winner
      for (int i = 0; i < NUM_PE; i++) begin
        k = (int'(ptr[b]) + i) % NUM_PE;
        if (!found && req_i[k] && int'(addr_i[k*AW+BANK_LSB +: BW]) == b) begin
          found  = 1'b1;
          win[b] = PW'(k);
        end
      end
      hit[b] = found;
      if (found) begin
        gnt_o[win[b]]                  = 1'b1;
        bank_req_o[b]                  = 1'b1;
        bank_we_o[b]                   = we_i[win[b]];
        bank_be_o[b*BEW +: BEW]        = we_i[win[b]] ? be_i[int'(win[b])*BEW +: BEW] : '0;
        bank_addr_o[b*AW +: AW]        = addr_i[int'(win[b])*AW +: AW];
        bank_wdata_o[b*DW +: DW]       = wdata_i[int'(win[b])*DW +: DW];
      end
    end
  end
  always_comb begin
    rdata_o = '0;
    for (int b = 0; b < NUM_BANK; b++)
      if (rsp_vld[b] && !rsp_we[b]) rdata_o[int'(rsp_pe[b])*DW +: DW] = bank_rdata_i[b*DW +: DW];
  end
  // a PE wins at most one bank per cycle, so registering gnt_o gives its rvalid directly
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr      <= '{default: '0};
      rsp_pe   <= '{default: '0};
      rsp_vld  <= '0;
      rsp_we   <= '0;
      rvalid_o <= '0;
    end else begin
      for (int b = 0; b < NUM_BANK; b++) begin
        if (hit[b]) ptr[b] <= PW'((int'(win[b]) + 1) % NUM_PE);
        rsp_pe[b] <= win[b];
      end
      rsp_vld  <= hit;
      rsp_we   <= bank_we_o;
      rvalid_o <= gnt_o;
    end
  end
endmodule

// File: tb/tb_mem_bank_xbar_rr.sv
// tb_mem_bank_xbar_rr: scoreboard bench for mem_bank_xbar_rr (4x4 and 3x8 builds)
module tb_mem_bank_xbar_rr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [3:0]   req, we, gnt, rvalid, breq, bwe;
  logic [15:0]  be, bbe;
  logic [127:0] addr, wdata, rdata, baddr, bwdata, brdata;
  assign be     = {4{4'b0011}};
  assign wdata  = {4{32'hA5A5A5A5}};
  assign brdata = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11110000};
  mem_bank_xbar_rr dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .bank_req_o(breq), .bank_we_o(bwe), .bank_be_o(bbe), .bank_addr_o(baddr),
    .bank_wdata_o(bwdata), .bank_rdata_i(brdata)
  );
  logic [2:0]   rqb, gntb, rvb;
  logic [95:0]  addrb, rdb;
  logic [7:0]   breqb, bweb;
  logic [31:0]  bbeb;
  logic [255:0] baddrb, bwdb;
  mem_bank_xbar_rr #(.NUM_PE(3), .NUM_BANK(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(rqb), .we_i(3'b000), .be_i(12'h0), .addr_i(addrb),
    .wdata_i(96'h0), .gnt_o(gntb), .rvalid_o(rvb), .rdata_o(rdb),
    .bank_req_o(breqb), .bank_we_o(bweb), .bank_be_o(bbeb), .bank_addr_o(baddrb),
    .bank_wdata_o(bwdb), .bank_rdata_i(256'h0)
  );
  typedef struct {int due; int pe; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [3:0]   erv;
  logic [127:0] erd;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic step(input logic [3:0] r, input logic [3:0] w, input logic [7:0] bs,
                      input logic [3:0] eg, input logic [3:0] eb, input bit push);
    exp_t e;
    req = r;
    we  = w;
    for (int p = 0; p < 4; p++) addr[p*32 +: 32] = {16'h0, bs[p*2 +: 2], 14'(p*4)};
    @(negedge clk);
    chk("gnt", 64'(gnt), 64'(eg));
    chk("bank_req", 64'(breq), 64'(eb));
    if (push)
      for (int p = 0; p < 4; p++)
        if (eg[p]) begin
          e.due  = cyc + 1;
          e.pe   = p;
          e.data = w[p] ? 32'h0 : brdata[int'(bs[p*2 +: 2])*32 +: 32];
          sb.push_back(e);
        end
  endtask
  task automatic stepb(input logic [2:0] r, input logic [8:0] bs, input logic [2:0] eg,
                       input logic [7:0] eb, input logic [2:0] erv_b);
    rqb = r;
    for (int p = 0; p < 3; p++) addrb[p*32 +: 32] = {15'h0, bs[p*3 +: 3], 14'h0};
    @(negedge clk);
    chk("b_gnt", 64'(gntb), 64'(eg));
    chk("b_bank_req", 64'(breqb), 64'(eb));
    chk("b_rvalid", 64'(rvb), 64'(erv_b));
    tick();
  endtask
  always @(negedge clk) begin
    erv = '0;
    erd = '0;
    if (rst) sb.delete();
    else
      while (sb.size() > 0 && sb[0].due == cyc) begin
        erv[sb[0].pe]           = 1'b1;
        erd[sb[0].pe*32 +: 32] = sb[0].data;
        void'(sb.pop_front());
      end
    chk("rvalid", 64'(rvalid), 64'(erv));
    for (int p = 0; p < 4; p++) chk("rdata", 64'(rdata[p*32 +: 32]), 64'(erd[p*32 +: 32]));
  end
  initial begin
    rst = 1'b1;
    req = '0;
    we = '0;
    addr = '0;
    rqb = '0;
    addrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_bank_req", 64'(breq), 64'h0);
    chk("rst_bank_we", 64'(bwe), 64'h0);
    chk("rst_bank_be", 64'(bbe), 64'h0);
    chk("rst_bank_addr", baddr[63:0], 64'h0);
    chk("rst_bank_wdata", bwdata[63:0], 64'h0);
    chk("rst_b_rvalid", 64'(rvb), 64'h0);
    tick();
    rst = 1'b0;
    step(4'b0001, 4'b0000, 8'b00_00_00_01, 4'b0001, 4'b0010, 1'b1);
    chk("bank1_addr", 64'(baddr[63:32]), 64'h4000);
    chk("bank_be_read", 64'(bbe), 64'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 4'h0, 8'b10_10_10_10, 4'(1 << (i % 4)), 4'b0100, 1'b1);
      tick();
    end
    step(4'hF, 4'h0, 8'b00_01_10_11, 4'hF, 4'hF, 1'b1);
    tick();
    step(4'b0010, 4'b0010, 8'h00, 4'b0010, 4'b0001, 1'b1);
    chk("bank_we", 64'(bwe), 64'h1);
    chk("bank_be_write", 64'(bbe), 64'h3);
    chk("bank_wdata", 64'(bwdata[31:0]), 64'hA5A5A5A5);
    chk("bank0_addr", 64'(baddr[31:0]), 64'h4);
    tick();
    step(4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b1);
    tick();
    step(4'b1100, 4'b0000, 8'b00_01_00_00, 4'b1100, 4'b0011, 1'b0);
    rst = 1'b1;
    tick();
    req = '0;
    @(negedge clk);
    chk("midrst_rvalid", 64'(rvalid), 64'h0);
    tick();
    rst = 1'b0;
    step(4'b1010, 4'b0000, 8'b01_00_01_00, 4'b0010, 4'b0010, 1'b1);
    tick();
    step(4'b1010, 4'b0000, 8'b01_00_01_00, 4'b1000, 4'b0010, 1'b1);
    tick();
    step(4'b0000, 4'b0000, 8'h00, 4'b0000, 4'b0000, 1'b1);
    tick();
    stepb(3'b100, {3'd5, 3'd0, 3'd0}, 3'b100, 8'h20, 3'b000);
    stepb(3'b101, {3'd5, 3'd0, 3'd5}, 3'b001, 8'h20, 3'b100);
    stepb(3'b101, {3'd5, 3'd0, 3'd5}, 3'b100, 8'h20, 3'b001);
    stepb(3'b000, 9'h0, 3'b000, 8'h00, 3'b100);
    repeat (2) tick();
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
